trigger_ctrl: RTL
=================

// Module: trigger_ctrl
// PURPOSE
// Sequences acquisition for the scope trigger path.
// - Writes the ADC sample stream into a 512-entry circular capture buffer.
// - Detects the trigger condition and counts post-trigger samples, then freezes the buffer.
// - Requests a snapshot copy from the display copier (read/ready handshake) and re-arms per mode.
// - Sits between the ADC front end, the capture RAM and the display snapshot copier.
// PARAMETERS
// DW        12      sample width
// AW        9       buffer address width (depth 2**AW = 512)
// PRE       256     samples kept before trigger point; post = 2**AW - PRE
// AUTO_TO   100000  auto-mode timeout in accepted samples (counter 20 bits)
// HYST      16      hysteresis band in LSBs (used only with TRIG_HYST_EN)
// PORTS
// clk          in   1   system clock
// rst          in   1   asynchronous reset, active-high
// arm          in   1   level; 1 = acquisition enabled
// mode         in   2   0 = auto, 1 = normal, 2 = single, 3 = treated as normal
// slope        in   1   0 = rising, 1 = falling
// level        in   DW  trigger threshold, unsigned
// s_valid      in   1   ADC sample strobe
// s_data       in   DW  ADC sample
// wr_en        out  1   capture RAM write enable
// wr_addr      out  AW  capture RAM write address
// wr_data      out  DW  capture RAM write data
// read         out  1   one-cycle copy request to snapshot copier
// ready        in   1   copier idle (1) / busy (0)
// win_start    out  AW  buffer address of oldest sample in frozen window
// triggered    out  1   1 from trigger event until re-arm
// forced       out  1   1 if current window was auto-forced
// state_o      out  3   current FSM state encoding
// BEHAVIOUR
// - Reset (async): all outputs 0; wr_addr = 0; state = IDLE; prev-sample, counters and hysteresis flag cleared.
// - Reset mid-operation aborts any capture or handoff. A pending copy is not re-requested.
// - State encodings: IDLE = 0, PREFILL = 1, ARMED = 2, POST = 3, REQ = 4, WAIT_BUSY = 5, WAIT_DONE = 6, STOP = 7.
// - Capture write (PREFILL, ARMED, POST) on each s_valid:
//   - wr_en = 1, wr_data = s_data, registered; one-cycle latency from s_valid.
//   - wr_addr increments mod 2**AW after each write (511 -> 0).
// - IDLE: arm = 1 -> PREFILL; the prefill count and timeout are cleared.
// - PREFILL: count PRE accepted samples, then -> ARMED. Trigger events are ignored, including on the PRE-th sample.
// - ARMED: prev/current are consecutive accepted samples.
//   - Rising trigger: prev < level and cur >= level.
//   - Falling trigger: prev > level and cur <= level.
//   - On trigger: trig_addr = write address of cur; triggered = 1; -> POST.
//   - Auto mode only: after AUTO_TO samples with no trigger, force a trigger on the next sample and set forced = 1.
// - POST: write 2**AW - PRE - 1 further samples, then -> REQ.
//   - win_start = trig_addr - PRE, modulo 2**AW.
// - REQ: read = 1 for exactly one cycle; wr_en = 0 from here until re-arm (buffer frozen) -> WAIT_BUSY.
// - WAIT_BUSY: wait for ready = 0, then -> WAIT_DONE.
//   - If ready stays 1 for 4096 cycles, re-issue read (single pulse) and restart the wait.
// - WAIT_DONE: on ready = 1, copy is complete.
//   - single -> STOP; auto/normal -> PREFILL with triggered = 0 and forced = 0.
// - STOP: hold the frozen window; arm falling -> IDLE (rising arm re-enters PREFILL via IDLE).
// - arm = 0 in PREFILL/ARMED/POST -> IDLE next cycle; the buffer keeps its contents.
// - arm = 0 in REQ/WAIT_* finishes the handshake first, then -> IDLE.
// - Changes to mode/slope/level take effect on the next sample compare; there is no re-prefill.
// - s_valid while frozen: dropped, not counted.
// CONFIGURATION
// - TRIG_HYST_EN defined:
//   - rising trigger additionally needs the signal to have gone below level - HYST (saturating at 0) since the last trigger/arm;
//   - falling trigger needs it above level + HYST (saturating at max).
//   - The arming flag is cleared on re-arm.
// - TRIG_HYST_EN undefined: plain two-sample crossing compare; HYST is unused.
// TESTING
// - Reset, arm = 1, mode = normal, level = 2048, ramp 0..4095 step 8 -> PREFILL 256 samples.
//   - Trigger at sample value 2048; 255 more writes; read pulse; win_start = trig_addr - 256.
// - Single mode: copier drops ready 3 cycles after read, raises it 520 cycles later -> STOP.
//   - wr_en stays 0; no second read.
// - Auto mode, constant input 100 -> forced = 1 after 100000 ARMED samples.
//   - The window completes and a new PREFILL starts after the copy.
// - Falling slope, square wave 3000/1000, level 2000 -> trigger on the first 1000 after a 3000.
//   - Rising edges do not trigger.
// - Async rst asserted in POST and mid-WAIT_DONE -> outputs 0 immediately.
//   - After release with arm = 1, PREFILL starts from wr_addr 0.
// - With TRIG_HYST_EN, HYST = 16, level = 2048: noise 2040..2056 around level after one trigger -> no retrigger.
//   - A dip to 2020 then a rise -> trigger.

Source files
------------

// File: rtl/trigger_ctrl.sv
// trigger_ctrl: scope acquisition sequencer (circular capture, trigger, post count, snapshot handoff).
// Optional hysteresis-qualified trigger when TRIG_HYST_EN is defined.
module trigger_ctrl #(
  parameter int DW      = 12,
  parameter int AW      = 9,
  parameter int PRE     = 256,
  parameter int AUTO_TO = 100000,
  parameter int HYST    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic [1:0]    mode,
  input  logic          slope,
  input  logic [DW-1:0] level,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          read,
  input  logic          ready,
  output logic [AW-1:0] win_start,
  output logic          triggered,
  output logic          forced,
  output logic [2:0]    state_o
);
  typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, REQ, WAIT_BUSY, WAIT_DONE, STOP} state_t;
  localparam logic [11:0]   PRE_L  = 12'(PRE - 1);
  localparam logic [11:0]   POST_L = 12'(2**AW - PRE - 2);
  localparam logic [19:0]   TO_MAX = 20'(AUTO_TO);
  localparam logic [AW-1:0] PRE_A  = AW'(PRE);
  state_t state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [19:0] to_q, to_d;
  logic [AW-1:0] addr_q, wr_addr_q, win_q, win_d;
  logic [DW-1:0] prev_q, wr_data_q;
  logic wr_en_q, trig_q, trig_d, forced_q, forced_d;
  logic capt, acc, rise, fall, hit, force_now, fire, rearm;
  assign capt = state_q inside {PREFILL, ARMED, POST};
  assign acc  = capt && arm && s_valid;
  assign rise = prev_q < level && s_data >= level;
  assign fall = prev_q > level && s_data <= level;
`ifdef TRIG_HYST_EN
  localparam logic [DW-1:0] HY = DW'(HYST);
  logic hy_q;
  logic [DW-1:0] lo, hi;
  assign lo  = level > HY ? level - HY : '0;
  assign hi  = level > {DW{1'b1}} - HY ? {DW{1'b1}} : level + HY;
  assign hit = hy_q && (slope ? fall : rise);
  // Band-exit flag: set once the signal leaves the far side of the band, cleared on trigger or re-arm.
  always_ff @(posedge clk or posedge rst)
    if (rst) hy_q <= 1'b0;
    else if (rearm || fire) hy_q <= 1'b0;
    else if (acc && state_q inside {PREFILL, ARMED}) hy_q <= hy_q | (slope ? s_data > hi : s_data < lo);
`else
  logic unused_hyst;
  assign unused_hyst = (HYST != 0) | rearm;
  assign hit = slope ? fall : rise;
`endif
  assign force_now = mode == 2'd0 && to_q == TO_MAX;
  assign fire      = acc && state_q == ARMED && (hit || force_now);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    trig_d   = trig_q;
    forced_d = forced_q;
    win_d    = win_q;
    case (state_q)
      IDLE:      state_d = arm ? PREFILL : IDLE;
      PREFILL:   if (!arm) state_d = IDLE;
                 else if (acc) begin
                   state_d = cnt_q == PRE_L ? ARMED : PREFILL;
                   cnt_d   = cnt_q == PRE_L ? '0 : cnt_q + 1'b1;
                 end
      ARMED:     if (!arm) state_d = IDLE;
                 else if (fire) begin
                   state_d  = POST;
                   cnt_d    = '0;
                   trig_d   = 1'b1;
                   forced_d = !hit;
                   win_d    = addr_q - PRE_A;
                 end else if (acc && to_q != TO_MAX) to_d = to_q + 1'b1;
      POST:      if (!arm) state_d = IDLE;
                 else if (acc) begin
                   state_d = cnt_q == POST_L ? REQ : POST;
                   cnt_d   = cnt_q + 1'b1;
                 end
      REQ:       begin
                   state_d = WAIT_BUSY;
                   cnt_d   = '0;
                 end
      WAIT_BUSY: if (!ready) state_d = WAIT_DONE;
                 else if (cnt_q == 12'hfff) state_d = REQ;
                 else cnt_d = cnt_q + 1'b1;
      WAIT_DONE: if (ready) state_d = !arm ? IDLE : mode == 2'd2 ? STOP : PREFILL;
      STOP:      state_d = arm ? STOP : IDLE;
      default:   state_d = IDLE;
    endcase
    rearm = state_d == PREFILL && state_q != PREFILL;
    if (rearm) begin
      cnt_d    = '0;
      to_d     = '0;
      trig_d   = 1'b0;
      forced_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      trig_q    <= 1'b0;
      forced_q  <= 1'b0;
      win_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      prev_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      trig_q   <= trig_d;
      forced_q <= forced_d;
      win_q    <= win_d;
      wr_en_q  <= acc;
      if (acc) begin
        wr_addr_q <= addr_q;
        addr_q    <= addr_q + 1'b1;
        wr_data_q <= s_data;
        prev_q    <= s_data;
      end
    end
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign read      = state_q == REQ;
  assign win_start = win_q;
  assign triggered = trig_q;
  assign forced    = forced_q;
  assign state_o   = state_q;
endmodule
